param_writeback_cache_controller: RTL and testbench



---
 rtl/cache_ctrl_pkg.sv | 18 +
 rtl/victim_rr_pointer.sv | 27 ++
 rtl/param_writeback_cache_controller.sv | 151 +++++++++++++++
 tb/tb_param_writeback_cache_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding and burst helpers for the writeback cache controller
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    READY     = 3'd0,
    WRITEBACK = 3'd1,
    MEMREAD   = 3'd2,
    WRITETHRU = 3'd3,
    NEXTINSTR = 3'd4,
    WAIT      = 3'd5
  } statetype;

  // True when the current beat index is the final word of the line.
  function automatic logic is_last_beat(input int unsigned beat, input int unsigned words);
    return beat == words - 1;
  endfunction

endpackage

// File: rtl/victim_rr_pointer.sv
// rtl/victim_rr_pointer.sv - round-robin replacement way pointer
module victim_rr_pointer #(
  parameter int WAYS = 2,
  parameter int VW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  output logic [VW-1:0] VictimWay
);

  generate
    if (WAYS == 1) begin : g_direct
      // A direct-mapped cache always replaces way 0.
      logic unused_inputs;
      assign unused_inputs = clk ^ reset ^ advance;
      assign VictimWay     = '0;
    end else begin : g_rr
      // Step to the next way after each completed fill; power-of-two WAYS wraps naturally.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) VictimWay <= '0;
        else if (advance) VictimWay <= VictimWay + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/param_writeback_cache_controller.sv
// rtl/param_writeback_cache_controller.sv - writeback/fill/write-through sequencer for an N-way data cache
module param_writeback_cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int WAYS           = 2,
  parameter int WRITE_ALLOCATE = 1,
  localparam int BW = $clog2(WORDS_PER_LINE),
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Hit,
  input  logic          Dirty,
  input  logic          MemWriteM,
  input  logic          MemtoRegM,
  input  logic          IStall,
  input  logic          BusReady,
  input  logic          BusError,
  input  logic [BW-1:0] WordOffset,
  output logic          Stall,
  output logic          CWE,
  output logic          BlockWE,
  output logic          DirtySet,
  output logic          HWriteM,
  output logic          MemRE,
  output logic          RDSel,
  output logic [BW-1:0] BeatCount,
  output logic [VW-1:0] VictimWay,
  output logic          Fault
);

  statetype state;
  logic     filled;     // NEXTINSTR was reached through a line fill, not a write-through
  logic     miss;
  logic     last_beat;
  logic     bus_err;
  logic     advance;

  assign miss      = (MemWriteM | MemtoRegM) & ~Hit;
  assign last_beat = is_last_beat(32'(BeatCount), WORDS_PER_LINE);
  assign bus_err   = BusReady & BusError;
  assign advance   = (state == MEMREAD) & BusReady & ~BusError & last_beat;

  victim_rr_pointer #(.WAYS(WAYS), .VW(VW)) u_victim (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .VictimWay (VictimWay)
  );

  // State, beat counter and fault pulse; a bus error in any burst state aborts to READY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= READY;
      BeatCount <= '0;
      Fault     <= 1'b0;
      filled    <= 1'b0;
    end else begin
      Fault <= 1'b0;
      case (state)
        READY: begin
          if (miss) begin
            if (MemWriteM && (WRITE_ALLOCATE == 0)) state <= WRITETHRU;
            else if (Dirty)                         state <= WRITEBACK;
            else                                    state <= MEMREAD;
          end
        end
        WRITEBACK: begin
          if (bus_err) begin
            state     <= READY;
            BeatCount <= '0;
            Fault     <= 1'b1;
          end else if (BusReady) begin
            if (last_beat) begin
              state     <= MEMREAD;
              BeatCount <= '0;
            end else begin
              BeatCount <= BeatCount + 1'b1;
            end
          end
        end
        MEMREAD: begin
          if (bus_err) begin
            state     <= READY;
            BeatCount <= '0;
            Fault     <= 1'b1;
          end else if (BusReady) begin
            if (last_beat) begin
              state     <= NEXTINSTR;
              BeatCount <= '0;
              filled    <= 1'b1;
            end else begin
              BeatCount <= BeatCount + 1'b1;
            end
          end
        end
        WRITETHRU: begin
          if (bus_err) begin
            state <= READY;
            Fault <= 1'b1;
          end else if (BusReady) begin
            state  <= NEXTINSTR;
            filled <= 1'b0;
          end
        end
        NEXTINSTR, WAIT: state <= IStall ? WAIT : READY;
        default:         state <= READY;
      endcase
    end
  end

  // Per-state control strobes; Stall and the array writes must react in the access cycle.
  always_comb begin
    Stall    = 1'b0;
    CWE      = 1'b0;
    BlockWE  = 1'b0;
    DirtySet = 1'b0;
    HWriteM  = 1'b0;
    MemRE    = 1'b0;
    RDSel    = 1'b0;
    case (state)
      READY: begin
        Stall    = miss;
        CWE      = Hit & MemWriteM;
        DirtySet = Hit & MemWriteM;
      end
      WRITEBACK: begin
        Stall   = 1'b1;
        HWriteM = 1'b1;
      end
      MEMREAD: begin
        Stall   = 1'b1;
        MemRE   = 1'b1;
        BlockWE = ~bus_err;
        CWE     = BusReady & ~BusError;
      end
      WRITETHRU: begin
        Stall   = 1'b1;
        HWriteM = 1'b1;
      end
      NEXTINSTR: begin
        RDSel    = (WordOffset == BW'(WORDS_PER_LINE - 1));
        CWE      = MemWriteM & filled;
        DirtySet = MemWriteM & filled;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_param_writeback_cache_controller.sv
// tb/tb_param_writeback_cache_controller.sv - directed vector bench for the writeback cache controller
module tb_param_writeback_cache_controller;

  logic clk = 1'b0;
  logic reset;
  logic Hit, Dirty, MemWriteM, MemtoRegM, IStall, BusReady, BusError;
  logic [1:0] wo4;
  logic [2:0] wo8;

  // packed outputs: {Stall, CWE, BlockWE, DirtySet, HWriteM, MemRE, RDSel, Fault}
  wire [7:0] a_o, b_o, c_o;
  wire [1:0] a_bc, b_bc;
  wire [2:0] c_bc;
  wire       a_vw, b_vw, c_vw;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_writeback_cache_controller #(.WORDS_PER_LINE(4), .WAYS(2), .WRITE_ALLOCATE(1)) dut_a (
    .clk(clk), .reset(reset), .Hit(Hit), .Dirty(Dirty), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM), .IStall(IStall), .BusReady(BusReady), .BusError(BusError),
    .WordOffset(wo4), .Stall(a_o[7]), .CWE(a_o[6]), .BlockWE(a_o[5]), .DirtySet(a_o[4]),
    .HWriteM(a_o[3]), .MemRE(a_o[2]), .RDSel(a_o[1]), .BeatCount(a_bc),
    .VictimWay(a_vw), .Fault(a_o[0]));

  param_writeback_cache_controller #(.WORDS_PER_LINE(4), .WAYS(2), .WRITE_ALLOCATE(0)) dut_b (
    .clk(clk), .reset(reset), .Hit(Hit), .Dirty(Dirty), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM), .IStall(IStall), .BusReady(BusReady), .BusError(BusError),
    .WordOffset(wo4), .Stall(b_o[7]), .CWE(b_o[6]), .BlockWE(b_o[5]), .DirtySet(b_o[4]),
    .HWriteM(b_o[3]), .MemRE(b_o[2]), .RDSel(b_o[1]), .BeatCount(b_bc),
    .VictimWay(b_vw), .Fault(b_o[0]));

  param_writeback_cache_controller #(.WORDS_PER_LINE(8), .WAYS(2), .WRITE_ALLOCATE(1)) dut_c (
    .clk(clk), .reset(reset), .Hit(Hit), .Dirty(Dirty), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM), .IStall(IStall), .BusReady(BusReady), .BusError(BusError),
    .WordOffset(wo8), .Stall(c_o[7]), .CWE(c_o[6]), .BlockWE(c_o[5]), .DirtySet(c_o[4]),
    .HWriteM(c_o[3]), .MemRE(c_o[2]), .RDSel(c_o[1]), .BeatCount(c_bc),
    .VictimWay(c_vw), .Fault(c_o[0]));

  typedef struct {
    logic       hit, dirty, mw, mr, br, be, istall;
    logic [1:0] wo;
    logic [7:0] exp;
    logic [1:0] bc;
    logic       vw;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic h, d, mw, mr, br, be, is, input logic [1:0] wo,
                              input logic [7:0] exp, input logic [1:0] bc, input logic vw);
    vec_t r;
    r = '{h, d, mw, mr, br, be, is, wo, exp, bc, vw};
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, d, mw, mr, br, be, is);
    Hit = h; Dirty = d; MemWriteM = mw; MemtoRegM = mr;
    BusReady = br; BusError = be; IStall = is;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    wo4 = '0;
    wo8 = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    wo4 = '0;
    wo8 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_a", {a_o, a_bc, a_vw}, 32'd0);
    chk("reset_b", {b_o, b_bc, b_vw}, 32'd0);
    chk("reset_c", {c_o, c_bc, c_vw}, 32'd0);
    tick();

    // W=4 N=2 allocate: hits, clean load miss, dirty store miss with stretched beats
    add(0,0,0,0,0,0,0,0, 8'b0000_0000, 0, 0);
    add(1,0,0,1,0,0,0,0, 8'b0000_0000, 0, 0);
    add(1,0,1,0,0,0,0,0, 8'b0101_0000, 0, 0);
    add(0,0,0,1,1,0,0,0, 8'b1000_0000, 0, 0);
    for (int b = 0; b < 4; b++) add(0,0,0,1,1,0,0,0, 8'b1110_0100, 2'(b), 0);
    add(0,0,0,1,0,0,0,3, 8'b0000_0010, 0, 1);
    add(0,0,0,0,0,0,0,0, 8'b0000_0000, 0, 1);
    add(0,1,1,0,1,0,0,0, 8'b1000_0000, 0, 1);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) add(0,1,1,0,0,0,0,0, 8'b1000_1000, 2'(b), 1);
      add(0,1,1,0,1,0,0,0, 8'b1000_1000, 2'(b), 1);
    end
    for (int b = 0; b < 4; b++) begin
      add(0,1,1,0,0,0,0,0, 8'b1010_0100, 2'(b), 1);
      add(0,1,1,0,1,0,0,0, 8'b1110_0100, 2'(b), 1);
    end
    add(0,1,1,0,0,0,0,1, 8'b0101_0000, 0, 0);
    add(0,0,0,0,0,0,0,0, 8'b0000_0000, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].hit, tbl[i].dirty, tbl[i].mw, tbl[i].mr, tbl[i].br, tbl[i].be, tbl[i].istall);
      wo4 = tbl[i].wo;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {a_o, a_bc, a_vw}, {tbl[i].exp, tbl[i].bc, tbl[i].vw});
      tick();
    end

    // no-allocate store miss: single write-through beat, no array writes
    do_reset();
    drive(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk); chk("wt_miss", b_o, 8'b1000_0000); tick();
    @(negedge clk); chk("wt_hold", b_o, 8'b1000_1000); tick();
    BusReady = 1'b1;
    @(negedge clk); chk("wt_beat", b_o, 8'b1000_1000); tick();
    BusReady = 1'b0;
    @(negedge clk); chk("wt_next", b_o, 8'b0000_0000); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("wt_ready", {b_o, b_bc, b_vw}, 32'd0); tick();

    // bus error on beat 2 of a fill: abort, fault pulse, victim pointer untouched
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 0);
    repeat (5) tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk); chk("err_pre_vw", a_vw, 1'b1); tick();
    drive(0, 0, 0, 1, 1, 0, 0);
    repeat (3) tick();
    BusError = 1'b1;
    @(negedge clk); chk("err_beat", {a_o, a_bc}, {8'b1000_0100, 2'd2}); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("err_fault", {a_o, a_bc, a_vw}, {8'b0000_0001, 2'd0, 1'b1}); tick();
    @(negedge clk); chk("err_pulse_end", a_o, 8'b0000_0000); tick();

    // asynchronous reset in the middle of a fill
    drive(0, 0, 0, 1, 1, 0, 0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mid", {a_o, a_bc, a_vw}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); chk("rst_nofault", a_o, 8'b0000_0000); tick();

    // W=8: eight-beat fill, IStall holds WAIT three cycles, RDSel only at offset 7
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 0);
    wo8 = 3'd7;
    @(negedge clk); chk("w8_miss", c_o, 8'b1000_0000); tick();
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); chk($sformatf("w8_beat%0d", b), {c_o, c_bc}, {8'b1110_0100, 3'(b)}); tick();
    end
    drive(0, 0, 0, 1, 0, 0, 1);
    @(negedge clk); chk("w8_next", {c_o, c_vw}, {8'b0000_0010, 1'b1}); tick();
    for (int k = 0; k < 3; k++) begin
      IStall = (k < 2);
      @(negedge clk); chk($sformatf("w8_wait%0d", k), c_o, 8'b0000_0000); tick();
    end
    drive(0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); chk("w8_ready", c_o, 8'b1000_0000); tick();
    repeat (8) tick();
    wo8 = 3'd3;
    drive(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk); chk("w8_rdsel_off", {c_o, c_vw}, {8'b0000_0000, 1'b0}); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
